elevator_dispatcher: RTL and testbench
======================================

ELEVATOR_DISPATCHER -- requirements
Module: elevator_dispatcher

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 16, cycles a command may wait for ready before the car is faulted (range 2..255).
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port floor_requests  in  4  level floor requests from the arbiter, bit i = floor i (0 = G).
REQ-005 SHALL have port emergency_override  in  1  halt all dispatching.
REQ-006 SHALL have ports car0_floor, car1_floor  in  2 each  current floor of each car.
REQ-007 SHALL have ports car0_busy, car1_busy  in  1 each  car moving or serving.
REQ-008 SHALL have ports car0_cmd_valid, car1_cmd_valid  out  1 each  command valid.
REQ-009 SHALL have ports car0_cmd_floor, car1_cmd_floor  out  2 each  target floor.
REQ-010 SHALL have ports car0_cmd_ready, car1_cmd_ready  in  1 each  command accepted.
REQ-011 SHALL have port pending_requests  out  4  latched, unserved floors.
REQ-012 SHALL have port car_fault  out  2  sticky per-car timeout fault.
REQ-013 SHALL have port halted  out  1  high while in HALT.

Function
REQ-014 SHALL latch rising edges of floor_requests (vs. 1-cycle-delayed copy) into pending_requests; set wins over a same-cycle clear of the same bit.
REQ-015 SHALL implement FSM IDLE, SELECT, ISSUE, HALT, all registered.
REQ-016 IDLE: emergency_override -> HALT; else pending nonzero and >=1 car available (!busy && !fault) -> SELECT; else stay.
REQ-017 SELECT (one cycle): floor = first pending bit searching upward from rr_ptr, wrapping 3->0; car = available car with smaller |car_floor - floor| (2-bit unsigned absolute difference); tie -> car opposite to last_car; -> ISSUE.
REQ-018 ISSUE: selected car's cmd_valid high and cmd_floor constant until handshake; the other car's cmd_valid low.
REQ-019 On valid && ready: clear that pending bit, rr_ptr <= floor+1 mod 4, last_car <= selected car, -> IDLE.
REQ-020 Timeout counter SHALL clear on entering ISSUE, increment each ISSUE cycle; ready absent when count reaches ACK_TIMEOUT-1 -> drop valid, set car_fault[car], floor stays pending, -> IDLE.
REQ-021 Faulted cars SHALL never be selected; both faulted -> remain IDLE with requests pending.
REQ-022 emergency_override in any state -> HALT next cycle; cmd_valid low, pending_requests cleared, edge history still tracked.
REQ-023 HALT: halted high; leave to IDLE the cycle after emergency_override deasserts; levels still held do not re-latch (no new edge).
REQ-024 Latency: request edge sampled at edge N -> cmd_valid high after edge N+3 when FSM idle and a car available.
REQ-025 At most one cmd_valid SHALL be high in any cycle.

Reset
REQ-026 rst_n low SHALL asynchronously force: state IDLE, pending_requests 0, edge history 0, rr_ptr 0, last_car 1, counter 0, car_fault 0, all cmd_valid 0, cmd_floor 0, halted 0.
REQ-027 Reset mid-ISSUE SHALL drop cmd_valid immediately with no handshake completion.

Structure
REQ-028 Package elevator_pkg SHALL hold NUM_FLOORS=4, FLOOR_W=2, FSM state encoding type, car index type.
REQ-029 Combinational sub-module car_selector SHALL compute floor and car choice (REQ-017); FSM, counters and registers stay in elevator_dispatcher.

Verification
REQ-030 Cars at 0 and 3 idle, pulse floor 2 -> car1_cmd_valid, floor 2, 3 cycles later; ready -> pending 0000.
REQ-031 Both cars at 1, pending 0101, rr_ptr 0 -> floor 0 to car0 (last_car 1), then floor 2 to car1.
REQ-032 car0 only available, ready held low -> valid held ACK_TIMEOUT cycles, car_fault=01, floor stays pending, next issue to car1 once not busy.
REQ-033 emergency_override during ISSUE -> valid low next cycle, halted=1, pending 0000; release -> IDLE, held levels not re-dispatched.
REQ-034 New edge on floor being accepted in same cycle -> bit remains set after handshake.
REQ-035 rst_n low mid-ISSUE -> all outputs at reset values without waiting for clk.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and constants for the two-car elevator dispatcher.
package elevator_pkg;

  localparam int NUM_FLOORS = 4;
  localparam int FLOOR_W    = 2;

  typedef logic [FLOOR_W-1:0] floor_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  // Car index: 0 = car0, 1 = car1.
  typedef logic car_idx_t;

  localparam car_idx_t CAR0 = 1'b0;
  localparam car_idx_t CAR1 = 1'b1;

  // Unsigned absolute floor distance.
  function automatic floor_t floor_dist(input floor_t a, input floor_t b);
    return (a > b) ? floor_t'(a - b) : floor_t'(b - a);
  endfunction

endpackage

// File: rtl/elevator_dispatcher_car_selector.sv
// Combinational choice of the next floor to serve and the car to send.
// Floor: first pending bit at or above rr_ptr, wrapping. Car: nearest
// available car; equal distance goes to the car not used last time.
module car_selector
  import elevator_pkg::*;
(
  input  logic [NUM_FLOORS-1:0] pending,
  input  floor_t                rr_ptr,
  input  floor_t                car0_floor,
  input  floor_t                car1_floor,
  input  logic                  car0_avail,
  input  logic                  car1_avail,
  input  car_idx_t              last_car,
  output logic                  sel_valid,
  output floor_t                sel_floor,
  output car_idx_t              sel_car
);

  logic   found;
  floor_t scan_idx;
  floor_t dist0;
  floor_t dist1;

  // Round-robin scan of pending floors starting at rr_ptr.
  always_comb begin
    found     = 1'b0;
    scan_idx  = '0;
    sel_floor = rr_ptr;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      scan_idx = rr_ptr + floor_t'(i);
      if (!found && pending[scan_idx]) begin
        sel_floor = scan_idx;
        found     = 1'b1;
      end
    end
  end

  // Nearest available car, ties alternate away from the last car used.
  always_comb begin
    dist0   = floor_dist(car0_floor, sel_floor);
    dist1   = floor_dist(car1_floor, sel_floor);
    sel_car = CAR0;
    if (car0_avail && car1_avail) begin
      if (dist0 < dist1)      sel_car = CAR0;
      else if (dist1 < dist0) sel_car = CAR1;
      else                    sel_car = ~last_car;
    end else if (car1_avail) begin
      sel_car = CAR1;
    end
    sel_valid = found && (car0_avail || car1_avail);
  end

endmodule

// File: rtl/elevator_dispatcher.sv
// Two-car elevator dispatcher: latches floor request edges, picks a floor
// and car, issues one command at a time with a ready timeout, and halts on
// emergency override.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a pending floor and an available car
// ST_SELECT | one cycle: capture floor/car choice from car_selector
// ST_ISSUE  | cmd_valid high to chosen car until ready or timeout
// ST_HALT   | emergency override active, nothing dispatched
module elevator_dispatcher
  import elevator_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] floor_requests,
  input  logic                  emergency_override,
  input  logic [FLOOR_W-1:0]    car0_floor,
  input  logic [FLOOR_W-1:0]    car1_floor,
  input  logic                  car0_busy,
  input  logic                  car1_busy,
  output logic                  car0_cmd_valid,
  output logic                  car1_cmd_valid,
  output logic [FLOOR_W-1:0]    car0_cmd_floor,
  output logic [FLOOR_W-1:0]    car1_cmd_floor,
  input  logic                  car0_cmd_ready,
  input  logic                  car1_cmd_ready,
  output logic [NUM_FLOORS-1:0] pending_requests,
  output logic [1:0]            car_fault,
  output logic                  halted
);

  localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

  state_t                state_q,     state_d;
  logic [NUM_FLOORS-1:0] req_sync_q,  req_sync_d;
  logic [NUM_FLOORS-1:0] req_prev_q,  req_prev_d;
  logic [NUM_FLOORS-1:0] pending_q,   pending_d;
  floor_t                rr_ptr_q,    rr_ptr_d;
  car_idx_t              last_car_q,  last_car_d;
  logic [7:0]            cnt_q,       cnt_d;
  logic [1:0]            fault_q,     fault_d;
  logic [1:0]            valid_q,     valid_d;
  floor_t                cmd_floor_q, cmd_floor_d;
  car_idx_t              sel_car_q,   sel_car_d;
  logic                  halted_q,    halted_d;

  logic [NUM_FLOORS-1:0] rise;
  logic [NUM_FLOORS-1:0] clr;
  logic                  avail0;
  logic                  avail1;
  logic                  issue_ready;
  logic                  sel_valid;
  floor_t                sel_floor;
  car_idx_t              sel_car;

  assign avail0      = !car0_busy && !fault_q[0];
  assign avail1      = !car1_busy && !fault_q[1];
  assign issue_ready = (sel_car_q == CAR1) ? car1_cmd_ready : car0_cmd_ready;
  assign rise        = req_sync_q & ~req_prev_q;

  car_selector u_car_selector (
    .pending    (pending_q),
    .rr_ptr     (rr_ptr_q),
    .car0_floor (car0_floor),
    .car1_floor (car1_floor),
    .car0_avail (avail0),
    .car1_avail (avail1),
    .last_car   (last_car_q),
    .sel_valid  (sel_valid),
    .sel_floor  (sel_floor),
    .sel_car    (sel_car)
  );

  // Next-state, request latching and registered-output computation.
  always_comb begin
    state_d     = state_q;
    req_sync_d  = floor_requests;
    req_prev_d  = req_sync_q;
    rr_ptr_d    = rr_ptr_q;
    last_car_d  = last_car_q;
    cnt_d       = cnt_q;
    fault_d     = fault_q;
    valid_d     = valid_q;
    cmd_floor_d = cmd_floor_q;
    sel_car_d   = sel_car_q;
    clr         = '0;

    case (state_q)
      ST_IDLE: begin
        if ((pending_q != '0) && (avail0 || avail1)) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        if (sel_valid) begin
          state_d     = ST_ISSUE;
          cmd_floor_d = sel_floor;
          sel_car_d   = sel_car;
          valid_d     = (sel_car == CAR1) ? 2'b10 : 2'b01;
          cnt_d       = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (issue_ready) begin
          clr[cmd_floor_q] = 1'b1;
          rr_ptr_d         = cmd_floor_q + floor_t'(1);
          last_car_d       = sel_car_q;
          valid_d          = 2'b00;
          state_d          = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          fault_d[sel_car_q] = 1'b1;
          valid_d            = 2'b00;
          state_d            = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_HALT: begin
        if (!emergency_override) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new edge on the floor just accepted keeps the bit set.
    pending_d = (pending_q & ~clr) | rise;

    if (emergency_override) begin
      state_d   = ST_HALT;
      valid_d   = 2'b00;
      pending_d = '0;
      cnt_d     = '0;
    end

    halted_d = (state_d == ST_HALT);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_sync_q  <= '0;
      req_prev_q  <= '0;
      pending_q   <= '0;
      rr_ptr_q    <= '0;
      last_car_q  <= CAR1;
      cnt_q       <= '0;
      fault_q     <= '0;
      valid_q     <= '0;
      cmd_floor_q <= '0;
      sel_car_q   <= CAR0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_sync_q  <= req_sync_d;
      req_prev_q  <= req_prev_d;
      pending_q   <= pending_d;
      rr_ptr_q    <= rr_ptr_d;
      last_car_q  <= last_car_d;
      cnt_q       <= cnt_d;
      fault_q     <= fault_d;
      valid_q     <= valid_d;
      cmd_floor_q <= cmd_floor_d;
      sel_car_q   <= sel_car_d;
      halted_q    <= halted_d;
    end
  end

  assign car0_cmd_valid   = valid_q[0];
  assign car1_cmd_valid   = valid_q[1];
  assign car0_cmd_floor   = cmd_floor_q;
  assign car1_cmd_floor   = cmd_floor_q;
  assign pending_requests = pending_q;
  assign car_fault        = fault_q;
  assign halted           = halted_q;

endmodule

// File: tb/tb_elevator_dispatcher.sv
// Bench for elevator_dispatcher: directed scenarios plus randomized
// dispatch traffic checked against a transaction-level dispatch model.
module tb_elevator_dispatcher;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] floor_requests = '0;
  logic       emergency_override = 1'b0;
  logic [1:0] car0_floor = '0, car1_floor = '0;
  logic       car0_busy = 1'b0, car1_busy = 1'b0;
  logic       car0_cmd_valid, car1_cmd_valid;
  logic [1:0] car0_cmd_floor, car1_cmd_floor;
  logic       car0_cmd_ready = 1'b0, car1_cmd_ready = 1'b0;
  logic [3:0] pending_requests;
  logic [1:0] car_fault;
  logic       halted;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: pending floors, round-robin start, last car.
  logic [3:0] m_pending;
  int         m_rr;
  int         m_last;

  elevator_dispatcher #(.ACK_TIMEOUT(TO)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .floor_requests     (floor_requests),
    .emergency_override (emergency_override),
    .car0_floor         (car0_floor),
    .car1_floor         (car1_floor),
    .car0_busy          (car0_busy),
    .car1_busy          (car1_busy),
    .car0_cmd_valid     (car0_cmd_valid),
    .car1_cmd_valid     (car1_cmd_valid),
    .car0_cmd_floor     (car0_cmd_floor),
    .car1_cmd_floor     (car1_cmd_floor),
    .car0_cmd_ready     (car0_cmd_ready),
    .car1_cmd_ready     (car1_cmd_ready),
    .pending_requests   (pending_requests),
    .car_fault          (car_fault),
    .halted             (halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    floor_requests = '0;
    emergency_override = 1'b0;
    car0_busy = 1'b0;
    car1_busy = 1'b0;
    car0_cmd_ready = 1'b0;
    car1_cmd_ready = 1'b0;
    car0_floor = '0;
    car1_floor = '0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    m_pending = '0;
    m_rr = 0;
    m_last = 1;
  endtask

  task automatic wait_valid(input int budget, output logic got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (car0_cmd_valid || car1_cmd_valid) got = 1'b1;
    end
  endtask

  function automatic int model_floor();
    for (int i = 0; i < 4; i++) begin
      if (m_pending[(m_rr + i) % 4]) return (m_rr + i) % 4;
    end
    return -1;
  endfunction

  function automatic int model_car(input int f, input int c0f, input int c1f,
                                   input bit a0, input bit a1);
    int d0, d1;
    d0 = (c0f > f) ? c0f - f : f - c0f;
    d1 = (c1f > f) ? c1f - f : f - c1f;
    if (a0 && !a1) return 0;
    if (a1 && !a0) return 1;
    if (d0 < d1) return 0;
    if (d1 < d0) return 1;
    return 1 - m_last;
  endfunction

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({car1_cmd_valid, car0_cmd_valid} !== 2'b00) begin
      n_err++; $display("FAIL reset_valid got=%b exp=00", {car1_cmd_valid, car0_cmd_valid});
    end
    n_vec++;
    if ({pending_requests, car_fault, halted} !== 7'd0) begin
      n_err++; $display("FAIL reset_status pend=%b fault=%b halted=%b exp=0", pending_requests, car_fault, halted);
    end
    n_vec++;
    if ({car0_cmd_floor, car1_cmd_floor} !== 4'd0) begin
      n_err++; $display("FAIL reset_cmd_floor got=%h exp=0", {car0_cmd_floor, car1_cmd_floor});
    end
  endtask

  task automatic test_latency();
    logic exp;
    do_reset();
    car0_floor = 2'd0;
    car1_floor = 2'd3;
    floor_requests = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 0) floor_requests = '0;
      exp = (k == 3);
      n_vec++;
      if (car1_cmd_valid !== exp || car0_cmd_valid !== 1'b0) begin
        n_err++; $display("FAIL latency_edge%0d got=%b%b exp=%b0", k, car1_cmd_valid, car0_cmd_valid, exp);
      end
    end
    n_vec++;
    if (car1_cmd_floor !== 2'd2) begin
      n_err++; $display("FAIL latency_floor got=%0d exp=2", car1_cmd_floor);
    end
    car1_cmd_ready = 1'b1;
    tick();
    car1_cmd_ready = 1'b0;
    n_vec++;
    if (pending_requests !== 4'b0000 || car1_cmd_valid !== 1'b0) begin
      n_err++; $display("FAIL latency_accept pend=%b valid=%b exp=0000/0", pending_requests, car1_cmd_valid);
    end
  endtask

  task automatic test_tie_break();
    logic got;
    do_reset();
    car0_floor = 2'd1;
    car1_floor = 2'd1;
    floor_requests = 4'b0101;
    tick();
    floor_requests = '0;
    wait_valid(10, got);
    n_vec++;
    if (!got || car0_cmd_valid !== 1'b1 || car0_cmd_floor !== 2'd0) begin
      n_err++; $display("FAIL tie_first got=%b v=%b%b floor=%0d exp car0 floor0", got, car1_cmd_valid, car0_cmd_valid, car0_cmd_floor);
    end
    car0_cmd_ready = 1'b1;
    tick();
    car0_cmd_ready = 1'b0;
    wait_valid(10, got);
    n_vec++;
    if (!got || car1_cmd_valid !== 1'b1 || car1_cmd_floor !== 2'd2) begin
      n_err++; $display("FAIL tie_second got=%b v=%b%b floor=%0d exp car1 floor2", got, car1_cmd_valid, car0_cmd_valid, car1_cmd_floor);
    end
    car1_cmd_ready = 1'b1;
    tick();
    car1_cmd_ready = 1'b0;
    n_vec++;
    if (pending_requests !== 4'b0000) begin
      n_err++; $display("FAIL tie_pending got=%b exp=0000", pending_requests);
    end
  endtask

  task automatic test_same_cycle_edge();
    logic got;
    do_reset();
    floor_requests = 4'b0010;
    tick();
    floor_requests = '0;
    wait_valid(10, got);
    n_vec++;
    if (!got || car0_cmd_valid !== 1'b1 || car0_cmd_floor !== 2'd1) begin
      n_err++; $display("FAIL edge_issue got=%b v=%b%b floor=%0d exp car0 floor1", got, car1_cmd_valid, car0_cmd_valid, car0_cmd_floor);
    end
    floor_requests = 4'b0010;
    tick();
    car0_cmd_ready = 1'b1;
    tick();
    car0_cmd_ready = 1'b0;
    floor_requests = '0;
    n_vec++;
    if (pending_requests !== 4'b0010 || car0_cmd_valid !== 1'b0) begin
      n_err++; $display("FAIL edge_set_wins pend=%b valid=%b exp=0010/0", pending_requests, car0_cmd_valid);
    end
    wait_valid(10, got);
    n_vec++;
    if (!got || car1_cmd_valid !== 1'b1 || car1_cmd_floor !== 2'd1) begin
      n_err++; $display("FAIL edge_redispatch got=%b v=%b%b floor=%0d exp car1 floor1", got, car1_cmd_valid, car0_cmd_valid, car1_cmd_floor);
    end
    car1_cmd_ready = 1'b1;
    tick();
    car1_cmd_ready = 1'b0;
  endtask

  task automatic test_halt();
    logic got, seen;
    do_reset();
    car0_floor = 2'd0;
    car1_floor = 2'd3;
    floor_requests = 4'b1000;
    wait_valid(10, got);
    n_vec++;
    if (!got || car1_cmd_valid !== 1'b1) begin
      n_err++; $display("FAIL halt_issue got=%b v=%b%b exp car1", got, car1_cmd_valid, car0_cmd_valid);
    end
    emergency_override = 1'b1;
    tick();
    n_vec++;
    if ({car1_cmd_valid, car0_cmd_valid} !== 2'b00 || halted !== 1'b1 || pending_requests !== 4'b0000) begin
      n_err++; $display("FAIL halt_enter v=%b%b halted=%b pend=%b exp 00/1/0000", car1_cmd_valid, car0_cmd_valid, halted, pending_requests);
    end
    repeat (3) tick();
    emergency_override = 1'b0;
    tick();
    n_vec++;
    if (halted !== 1'b0) begin
      n_err++; $display("FAIL halt_release halted=%b exp=0", halted);
    end
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (car0_cmd_valid || car1_cmd_valid || pending_requests != 4'b0) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++; $display("FAIL halt_no_relatch activity=%b exp=0", seen);
    end
    floor_requests = '0;
  endtask

  task automatic test_timeout();
    logic got, seen;
    int   cnt;
    do_reset();
    car0_floor = 2'd0;
    car1_floor = 2'd3;
    car1_busy = 1'b1;
    floor_requests = 4'b0100;
    tick();
    floor_requests = '0;
    wait_valid(10, got);
    cnt = got ? 1 : 0;
    for (int i = 0; i < 3 * TO && got; i++) begin
      tick();
      if (car0_cmd_valid) cnt++;
      else break;
    end
    n_vec++;
    if (cnt != TO) begin
      n_err++; $display("FAIL timeout_len got=%0d exp=%0d", cnt, TO);
    end
    n_vec++;
    if (car_fault !== 2'b01 || pending_requests !== 4'b0100) begin
      n_err++; $display("FAIL timeout_fault fault=%b pend=%b exp=01/0100", car_fault, pending_requests);
    end
    car1_busy = 1'b0;
    wait_valid(10, got);
    n_vec++;
    if (!got || car1_cmd_valid !== 1'b1 || car0_cmd_valid !== 1'b0 || car1_cmd_floor !== 2'd2) begin
      n_err++; $display("FAIL timeout_reissue got=%b v=%b%b floor=%0d exp car1 floor2", got, car1_cmd_valid, car0_cmd_valid, car1_cmd_floor);
    end
    repeat (TO + 2) tick();
    n_vec++;
    if (car_fault !== 2'b11 || pending_requests !== 4'b0100) begin
      n_err++; $display("FAIL both_fault fault=%b pend=%b exp=11/0100", car_fault, pending_requests);
    end
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (car0_cmd_valid || car1_cmd_valid) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++; $display("FAIL both_fault_idle valid_seen=%b exp=0", seen);
    end
  endtask

  task automatic test_reset_mid_issue();
    logic got;
    do_reset();
    floor_requests = 4'b0001;
    tick();
    floor_requests = '0;
    wait_valid(10, got);
    n_vec++;
    if (!got) begin
      n_err++; $display("FAIL async_reset_setup valid=%b exp=1", got);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({car1_cmd_valid, car0_cmd_valid, pending_requests, car_fault, halted,
         car0_cmd_floor, car1_cmd_floor} !== 13'd0) begin
      n_err++; $display("FAIL async_reset v=%b%b pend=%b fault=%b halted=%b exp all 0",
                        car1_cmd_valid, car0_cmd_valid, pending_requests, car_fault, halted);
    end
    do_reset();
  endtask

  task automatic test_random();
    logic       got;
    logic [1:0] vp, exp_vp;
    int         ef, ec, b, d;
    do_reset();
    for (int t = 0; t < 40; t++) begin
      if (m_pending == 4'b0) begin
        car0_floor = 2'($urandom_range(0, 3));
        car1_floor = 2'($urandom_range(0, 3));
        b = $urandom_range(0, 2);
        car0_busy = (b == 1);
        car1_busy = (b == 2);
        m_pending = 4'($urandom_range(1, 15));
        floor_requests = m_pending;
        repeat ($urandom_range(1, 3)) tick();
        floor_requests = '0;
      end
      ef = model_floor();
      ec = model_car(ef, int'(car0_floor), int'(car1_floor), !car0_busy, !car1_busy);
      exp_vp = (ec == 1) ? 2'b10 : 2'b01;
      wait_valid(20, got);
      n_vec++;
      if (!got) begin
        n_err++; $display("FAIL rand_wait txn=%0d valid never seen exp car%0d floor%0d", t, ec, ef);
        break;
      end
      vp = {car1_cmd_valid, car0_cmd_valid};
      n_vec++;
      if (vp !== exp_vp) begin
        n_err++; $display("FAIL rand_car txn=%0d got=%b exp=%b", t, vp, exp_vp);
      end
      n_vec++;
      if (int'((ec == 1) ? car1_cmd_floor : car0_cmd_floor) != ef) begin
        n_err++; $display("FAIL rand_floor txn=%0d got=%0d exp=%0d", t, (ec == 1) ? car1_cmd_floor : car0_cmd_floor, ef);
      end
      n_vec++;
      if (pending_requests !== m_pending) begin
        n_err++; $display("FAIL rand_pending txn=%0d got=%b exp=%b", t, pending_requests, m_pending);
      end
      d = $urandom_range(0, 3);
      for (int k = 0; k < d; k++) begin
        tick();
        n_vec++;
        if ({car1_cmd_valid, car0_cmd_valid} !== exp_vp) begin
          n_err++; $display("FAIL rand_hold txn=%0d got=%b exp=%b", t, {car1_cmd_valid, car0_cmd_valid}, exp_vp);
        end
      end
      if (ec == 1) car1_cmd_ready = 1'b1;
      else         car0_cmd_ready = 1'b1;
      tick();
      car0_cmd_ready = 1'b0;
      car1_cmd_ready = 1'b0;
      m_pending[ef] = 1'b0;
      m_rr = (ef + 1) % 4;
      m_last = ec;
      n_vec++;
      if (pending_requests !== m_pending || {car1_cmd_valid, car0_cmd_valid} !== 2'b00) begin
        n_err++; $display("FAIL rand_accept txn=%0d pend=%b exp=%b valid=%b%b", t, pending_requests, m_pending, car1_cmd_valid, car0_cmd_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_tie_break();
    test_same_cycle_edge();
    test_halt();
    test_random();
    test_timeout();
    test_reset_mid_issue();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
